fetch_pc_unit: RTL and testbench

Program-counter and instruction-fetch sequencer for the 19-bit core. It consumes branch resolutions produced by the control-flow units (bne and siblings), holds the architectural PC, issues fetch requests to instruction memory, and buffers one returned instruction for decode. Taken branches squash any stale in-flight or buffered instruction.

---
 rtl/fetch_pc_if.sv | 42 ++++
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 tb/tb_fetch_pc_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// fetch_pc_if
// Bundles the three handshakes around the fetch sequencer:
//   branch resolution in  : branch_valid, branch_taken, branch_target
//   instruction memory    : imem_req_valid/ready/addr out, imem_rsp_valid/data back
//   decode hand-off       : instr_valid/data/pc out, instr_ready back
// The master modport is the fetch unit; the slave modport is its environment
// (control-flow units, instruction memory and decode seen as one party).
interface fetch_pc_if #(
    parameter int ADDR_W  = 19,
    parameter int INSTR_W = 19
);
    logic               branch_valid;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        input  branch_valid, branch_taken, branch_target,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        output branch_valid, branch_taken, branch_target,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Holds the architectural PC of the 19-bit core, issues one fetch at a time to
// instruction memory and buffers the returned word for decode. A taken branch
// redirects the PC from any state and squashes whatever fetch is in flight or
// buffered.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fetch_pc_if.master (branch input, imem request/response, decode output)
module fetch_pc_unit #(
    parameter int               ADDR_W   = 19,
    parameter int               INSTR_W  = 19,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  ipc_q;
    logic               latch_rsp;
    logic               taken;
    logic               handshake;

    assign taken     = bus.branch_valid & bus.branch_taken;
    assign handshake = bus.imem_req_valid & bus.imem_req_ready;

    // Request is suppressed during reset so memory never sees a fetch from a
    // state that is about to be discarded.
    assign bus.imem_req_valid = (state_q == ST_REQ) & ~rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == ST_HOLD);
    assign bus.instr_data     = data_q;
    assign bus.instr_pc       = ipc_q;

    // State, PC and the decode buffer. The buffer is only written when a
    // non-squashed response lands in WAIT, so it stays stable while decode stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            data_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (latch_rsp) begin
                data_q <= bus.imem_rsp_data;
                ipc_q  <= pc_q;
            end
        end
    end

    // Next-state logic. A taken branch always overrides the PC; the state only
    // decides whether a stale response still has to be swallowed (DRAIN) before
    // the redirected fetch can go out. A branch in HOLD beats a same-cycle
    // decode accept, so the PC becomes the target rather than target+1.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        latch_rsp = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    state_d = taken ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (taken) begin
                        state_d = ST_REQ;
                    end else begin
                        latch_rsp = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (taken) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (taken) begin
                    state_d = ST_REQ;
                end else if (bus.instr_ready) begin
                    state_d = ST_REQ;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (taken) begin
            pc_d = bus.branch_target;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared against a transaction-level reference model (PC, an
// outstanding-fetch flag with a stale marker, and a one-entry decode buffer).
// A small memory model answers each accepted request after a chosen latency.
module tb_fetch_pc_unit;

    localparam int AW = 19;
    localparam int IW = 19;

    logic clk;
    logic rst;

    fetch_pc_if #(.ADDR_W(AW), .INSTR_W(IW)) ifc ();

    fetch_pc_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Stimulus knobs for the next cycle; branch and reset are one-shot.
    logic          do_rst;
    logic          br_valid;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          mem_ready;
    logic          dec_ready;
    int            lat_k;
    bit            checking;

    // Memory model.
    bit            mem_busy;
    int            mem_delay;
    logic [AW-1:0] mem_addr;

    // Reference model.
    logic [AW-1:0] m_pc;
    bit            m_out;
    bit            m_stale;
    bit            m_buf;
    logic [IW-1:0] m_bdata;
    logic [AW-1:0] m_bpc;

    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
        return a ^ 19'h2AAAA;
    endfunction

    task automatic checkValue(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_req;
        exp_req = !do_rst && !m_buf && !m_out;
        checkValue("req_valid", AW'(ifc.imem_req_valid), AW'(exp_req));
        checkValue("req_addr", ifc.imem_req_addr, m_pc);
        checkValue("instr_valid", AW'(ifc.instr_valid), AW'(m_buf));
        checkValue("instr_data", ifc.instr_data, m_bdata);
        checkValue("instr_pc", ifc.instr_pc, m_bpc);
    endtask

    // One clock cycle: drive inputs, compare, advance model and memory, clock.
    task automatic applyStimulus();
        logic          rsp_v;
        logic [IW-1:0] rsp_d;
        logic          taken;
        logic          hs;
        rsp_v = mem_busy && (mem_delay == 0);
        rsp_d = memWord(mem_addr);
        rst                = do_rst;
        ifc.branch_valid   = br_valid;
        ifc.branch_taken   = br_taken;
        ifc.branch_target  = br_target;
        ifc.imem_req_ready = mem_ready;
        ifc.imem_rsp_valid = rsp_v;
        ifc.imem_rsp_data  = rsp_d;
        ifc.instr_ready    = dec_ready;
        #1;
        if (checking) checkOutput();
        hs    = ifc.imem_req_valid && mem_ready;
        taken = br_valid && br_taken;

        if (do_rst) begin
            m_pc = '0; m_out = 0; m_stale = 0; m_buf = 0; m_bdata = '0; m_bpc = '0;
        end else if (!m_buf && !m_out) begin
            if (mem_ready) begin
                m_out   = 1;
                m_stale = taken;
            end
            if (taken) m_pc = br_target;
        end else if (m_out) begin
            if (rsp_v) begin
                m_out = 0;
                if (!m_stale && !taken) begin
                    m_buf   = 1;
                    m_bdata = rsp_d;
                    m_bpc   = m_pc;
                end
            end else if (taken) begin
                m_stale = 1;
            end
            if (taken) m_pc = br_target;
        end else begin
            if (taken) begin
                m_buf = 0;
                m_pc  = br_target;
            end else if (dec_ready) begin
                m_buf = 0;
                m_pc  = m_pc + 1;
            end
        end

        if (do_rst) begin
            mem_busy = 0;
        end else begin
            if (rsp_v) mem_busy = 0;
            else if (mem_busy) mem_delay--;
            if (hs) begin
                mem_busy  = 1;
                mem_addr  = ifc.imem_req_addr;
                mem_delay = lat_k - 1;
            end
        end

        @(posedge clk);
        #1;
        do_rst = 0; br_valid = 0; br_taken = 0;
        rst = 0; ifc.branch_valid = 0; ifc.branch_taken = 0; ifc.imem_rsp_valid = 0;
    endtask

    task automatic takeBranch(input logic [AW-1:0] target);
        br_valid  = 1;
        br_taken  = 1;
        br_target = target;
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!ifc.instr_valid && n < 40) begin
            applyStimulus();
            n++;
        end
        if (!ifc.instr_valid) checkValue(tag, AW'(ifc.instr_valid), AW'(1));
    endtask

    initial begin
        do_rst = 1; br_valid = 0; br_taken = 0; br_target = '0;
        mem_ready = 1; dec_ready = 1; lat_k = 1; checking = 0;
        mem_busy = 0; mem_delay = 0; mem_addr = '0;
        m_pc = '0; m_out = 0; m_stale = 0; m_buf = 0; m_bdata = '0; m_bpc = '0;
        rst = 1;
        ifc.branch_valid = 0; ifc.branch_taken = 0; ifc.branch_target = '0;
        ifc.imem_req_ready = 0; ifc.imem_rsp_valid = 0; ifc.imem_rsp_data = '0;
        ifc.instr_ready = 0;

        $display("[TB] reset");
        applyStimulus();
        checking = 1;
        do_rst = 1;
        applyStimulus();

        $display("[TB] back-to-back fetch, k=1");
        for (int c = 1; c <= 9; c++) begin
            checkValue("t1_valid", AW'(ifc.instr_valid), AW'(c % 3 == 0));
            if (c % 3 == 1) checkValue("t1_addr", ifc.imem_req_addr, AW'((c - 1) / 3));
            if (c % 3 == 0) begin
                checkValue("t1_pc", ifc.instr_pc, AW'(c / 3 - 1));
                checkValue("t1_data", ifc.instr_data, memWord(AW'(c / 3 - 1)));
            end
            applyStimulus();
        end

        $display("[TB] decode stall at 150");
        takeBranch(19'd150);
        applyStimulus();
        dec_ready = 0;
        waitValid("t2_wait");
        for (int s = 0; s < 5; s++) begin
            checkValue("t2_hold_pc", ifc.instr_pc, 19'd150);
            checkValue("t2_hold_data", ifc.instr_data, memWord(19'd150));
            checkValue("t2_no_req", AW'(ifc.imem_req_valid), AW'(0));
            applyStimulus();
        end
        dec_ready = 1;
        applyStimulus();
        checkValue("t2_next_addr", ifc.imem_req_addr, 19'd151);

        $display("[TB] branch during WAIT, k=3");
        mem_ready = 0;
        takeBranch(19'd150);
        applyStimulus();
        checkValue("t3_req_addr", ifc.imem_req_addr, 19'd150);
        mem_ready = 1; lat_k = 3; dec_ready = 0;
        applyStimulus();
        takeBranch(19'd500);
        applyStimulus();
        waitValid("t3_wait");
        checkValue("t3_pc", ifc.instr_pc, 19'd500);
        checkValue("t3_data", ifc.instr_data, memWord(19'd500));

        $display("[TB] branch in HOLD with decode ready");
        takeBranch(19'd500);
        dec_ready = 1;
        applyStimulus();
        checkValue("t4_taken_addr", ifc.imem_req_addr, 19'd500);
        dec_ready = 0; lat_k = 1;
        waitValid("t4_wait_a");
        takeBranch(19'd150);
        applyStimulus();
        waitValid("t4_wait_b");
        br_valid = 1; br_taken = 0; br_target = 19'd999; dec_ready = 1;
        applyStimulus();
        checkValue("t4_not_taken", ifc.imem_req_addr, 19'd151);

        $display("[TB] pc wrap");
        mem_ready = 0;
        takeBranch(19'h7FFFF);
        applyStimulus();
        checkValue("t5_top_addr", ifc.imem_req_addr, 19'h7FFFF);
        mem_ready = 1; dec_ready = 0;
        waitValid("t5_wait");
        checkValue("t5_pc", ifc.instr_pc, 19'h7FFFF);
        dec_ready = 1;
        applyStimulus();
        checkValue("t5_wrap_addr", ifc.imem_req_addr, 19'd0);

        $display("[TB] address change under backpressure, reset mid-WAIT");
        mem_ready = 0; dec_ready = 0;
        applyStimulus();
        takeBranch(19'd500);
        applyStimulus();
        checkValue("t6_switch", ifc.imem_req_addr, 19'd500);
        applyStimulus();
        applyStimulus();
        mem_ready = 1; lat_k = 3;
        applyStimulus();
        applyStimulus();
        do_rst = 1;
        applyStimulus();
        checkValue("t6_rst_addr", ifc.imem_req_addr, 19'd0);
        checkValue("t6_rst_valid", AW'(ifc.instr_valid), AW'(0));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            do_rst    = ($urandom_range(199) == 0);
            br_valid  = ($urandom_range(9) == 0);
            br_taken  = 1'($urandom_range(1));
            br_target = AW'($urandom);
            mem_ready = ($urandom_range(3) != 0);
            dec_ready = ($urandom_range(4) < 3);
            lat_k     = int'($urandom_range(4, 1));
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
